// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one transmitter between two detector channels.
// Requests are latched as pending bits and served one at a time through IDLE/START/BUSY/RELEASE.
module tx_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       tx_done,
    input  logic       err_clr,
    output logic       tx_start,
    output logic       tx_sel,
    output logic       grant0,
    output logic       grant1,
    output logic       get_back0,
    output logic       get_back1,
    output logic       timeout_err,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [1:0] pend_q, pend_d;
    logic [1:0] pend_clr;
    logic       last_q, last_d;
    logic [7:0] cnt_q, cnt_d;
    logic       sel_q, sel_d;
    logic       err_q, err_d;
    logic       err_set;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pend_q  <= 2'b00;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
            sel_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        pend_clr  = 2'b00;
        err_set   = 1'b0;
        tx_start  = 1'b0;
        grant0    = 1'b0;
        grant1    = 1'b0;
        get_back0 = 1'b0;
        get_back1 = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_q != 2'b00) begin
                    state_d = START;
                    // With both pending, the channel not served last wins.
                    sel_d   = (pend_q == 2'b11) ? ~last_q : pend_q[1];
                end
            end
            START: begin
                tx_start = 1'b1;
                grant0   = ~sel_q;
                grant1   = sel_q;
                pend_clr = sel_q ? 2'b10 : 2'b01;
                cnt_d    = 8'd0;
                state_d  = BUSY;
            end
            BUSY: begin
                grant0 = ~sel_q;
                grant1 = sel_q;
                if (tx_done) begin
                    state_d = RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASE;
                    err_set = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RELEASE: begin
                get_back0 = ~sel_q;
                get_back1 = sel_q;
                last_d    = sel_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A new request in the same cycle as its clear keeps the channel pending.
        pend_d = {req1, req0} | (pend_q & ~pend_clr);
        err_d  = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    assign tx_sel      = sel_q;
    assign timeout_err = err_q;
    assign state_dbg   = state_q;

endmodule
